// File: rtl/branch_resolve_unit.sv
// Branch resolution: turns comparator flags into taken/not-taken, flags mispredicts, trains the predictor.
// Latency: BrUn/stall_ex combinational; redirect, update-queue push and counters visible one cycle after resolve.
// Backpressure: a full update queue stalls conditional branches in EX via stall_ex; upd_valid/upd_ready drains it.
//
// Ports:
//   clk, rst                     clock and async active-high reset
//   ex_*                         instruction in EX plus its fetch-time prediction
//   BrEq, BrLT / BrUn            comparator flags in, unsigned select out
//   stall_ex                     hold EX while the update queue is full
//   redirect_valid, redirect_pc  one-cycle registered flush with the corrected next PC
//   upd_*                        predictor training queue head (valid/ready)
//   br_cnt, mis_cnt              saturating performance counters

// Generic FIFO with registered storage. Head is readable while popVld is high.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushVld,
  input  logic [WIDTH-1:0] pushDat,
  output logic             full,
  output logic             popVld,
  input  logic             popRdy,
  output logic [WIDTH-1:0] popDat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign popVld = (count != '0);
  assign popDat = mem[rdPtr];
  assign doPush = pushVld & ~full;
  assign doPop  = popVld & popRdy;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      if (doPush && !doPop)      count <= count + (AW+1)'(1);
      else if (!doPush && doPop) count <= count - (AW+1)'(1);
    end
  end
endmodule

module branch_resolve_unit #(
  parameter int XLEN     = 32,
  parameter int UQ_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic            ex_is_jmp,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            BrUn,
  output logic            stall_ex,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic            upd_mispred,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [0:0]      state;
  logic            queueFull;
  logic            legalF3;
  logic            isCondBr;
  logic            brTaken;
  logic            taken;
  logic            mispred;
  logic            resolve;
  logic            resolveLegal;
  logic            doRedirect;
  logic            doPush;
  logic [XLEN-1:0] nextPc;

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
  assign BrUn = ex_funct3[1];

  // Conservative: a pop in this same cycle does not release the stall.
  assign stall_ex = ex_valid & ex_is_br & queueFull & ~redirect_valid;

  // funct3 010/011 are not branch encodings. A jump flag overrides the branch flag.
  assign legalF3  = (ex_funct3[2:1] != 2'b01);
  assign isCondBr = ex_is_br & ~ex_is_jmp & legalF3;

  always_comb begin
    brTaken = 1'b0;
    case (ex_funct3)
      3'b000:         brTaken = BrEq;
      3'b001:         brTaken = ~BrEq;
      3'b100, 3'b110: brTaken = BrLT;
      3'b101, 3'b111: brTaken = ~BrLT;
      default:        brTaken = 1'b0;
    endcase
  end

  assign taken   = ex_is_jmp | (isCondBr & brTaken);
  assign nextPc  = taken ? ex_target : ex_pc + XLEN'(4);
  assign mispred = (ex_pred_taken != taken) | (taken & (ex_pred_target != ex_target));

  // While the redirect pulse is out, whatever sits in EX is wrong-path.
  assign resolve      = ex_valid & (ex_is_br | ex_is_jmp) & ~stall_ex & ~redirect_valid;
  assign resolveLegal = resolve & (ex_is_jmp | isCondBr);
  assign doRedirect   = resolveLegal & mispred;
  assign doPush       = resolve & isCondBr;

  assign redirect_valid = (state == SQUASH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      redirect_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (doRedirect) begin
            state       <= SQUASH;
            redirect_pc <= nextPc;
          end
        end
        SQUASH:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (doPush && (br_cnt != '1))      br_cnt  <= br_cnt + CNT_W'(1);
      if (doRedirect && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  fifo #(
    .WIDTH (XLEN + 2),
    .DEPTH (UQ_DEPTH)
  ) updQueue (
    .clk     (clk),
    .rst     (rst),
    .pushVld (doPush),
    .pushDat ({ex_pc, taken, mispred}),
    .full    (queueFull),
    .popVld  (upd_valid),
    .popRdy  (upd_ready),
    .popDat  ({upd_pc, upd_taken, upd_mispred})
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_br, ex_is_jmp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken, BrEq, BrLT;
  logic        BrUn, stall_ex, redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid, upd_ready, upd_taken, upd_mispred;
  logic [31:0] upd_pc, br_cnt, mis_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
  } ent_t;

  // Reference state: expected queue contents, redirect register, counters.
  ent_t        q[$];
  logic        mRedir;
  logic [31:0] mRedirPc;
  logic [31:0] mBr;
  logic [31:0] mMis;

  branch_resolve_unit #(.XLEN(32), .UQ_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .stall_ex(stall_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptgt, input logic eq, input logic lt);
    ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    BrEq = eq; BrLT = lt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic refTaken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic resetModel();
    q.delete();
    mRedir = 1'b0; mRedirPc = 32'd0; mBr = 32'd0; mMis = 32'd0;
  endtask

  // Check all outputs against the reference for the current cycle, then advance one clock.
  task automatic tick();
    logic        expStall, res, isJ, legal, tk, mis, doPop, doPush, newRedir;
    logic [31:0] npc;
    ent_t        e;
    #1;
    expStall = ex_valid && ex_is_br && (q.size() == 4) && !mRedir;
    chk1("stall_ex", stall_ex, expStall);
    chk1("BrUn", BrUn, ex_funct3 inside {3'd2, 3'd3, 3'd6, 3'd7});
    chk1("redirect_valid", redirect_valid, mRedir);
    chk32("redirect_pc", redirect_pc, mRedirPc);
    chk1("upd_valid", upd_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk32("upd_pc", upd_pc, q[0].pc);
      chk1("upd_taken", upd_taken, q[0].taken);
      chk1("upd_mispred", upd_mispred, q[0].mis);
    end
    chk32("br_cnt", br_cnt, mBr);
    chk32("mis_cnt", mis_cnt, mMis);

    res   = ex_valid && (ex_is_br || ex_is_jmp) && !expStall && !mRedir;
    isJ   = ex_is_jmp;
    legal = ex_is_br && !ex_is_jmp && !(ex_funct3 inside {3'd2, 3'd3});
    tk    = isJ ? 1'b1 : (legal ? refTaken(ex_funct3, BrEq, BrLT) : 1'b0);
    npc   = tk ? ex_target : ex_pc + 32'd4;
    mis   = (ex_pred_taken != tk) || (tk && ex_pred_target != ex_target);
    doPop    = (q.size() > 0) && upd_ready;
    doPush   = res && legal;
    newRedir = res && (isJ || legal) && mis;
    e.pc = ex_pc; e.taken = tk; e.mis = mis;

    @(posedge clk);
    #1;
    if (doPop) void'(q.pop_front());
    if (doPush) begin
      q.push_back(e);
      if (mBr != 32'hFFFF_FFFF) mBr = mBr + 32'd1;
    end
    if (newRedir) begin
      mRedirPc = npc;
      if (mMis != 32'hFFFF_FFFF) mMis = mMis + 32'd1;
    end
    mRedir = newRedir;
  endtask

  initial begin
    resetModel();
    idle();
    upd_ready = 1'b1;
    rst = 1'b1;
    #2;
    chk1("rst_redirect_valid", redirect_valid, 1'b0);
    chk1("rst_upd_valid", upd_valid, 1'b0);
    chk32("rst_upd_pc", upd_pc, 32'd0);
    chk32("rst_br_cnt", br_cnt, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // BEQ taken, correctly predicted
    drive(1, 1, 0, 3'b000, 32'h40, 32'h100, 1, 32'h100, 1, 0);
    tick();
    idle();
    #1;
    chk1("beq_no_redirect", redirect_valid, 1'b0);
    chk32("beq_upd_pc", upd_pc, 32'h40);
    chk1("beq_upd_taken", upd_taken, 1'b1);
    chk1("beq_upd_mispred", upd_mispred, 1'b0);
    chk32("beq_br_cnt", br_cnt, 32'd1);
    chk32("beq_mis_cnt", mis_cnt, 32'd0);
    tick();

    // BLTU not taken but predicted taken
    drive(1, 1, 0, 3'b110, 32'h200, 32'h300, 1, 32'h300, 0, 0);
    #1;
    chk1("bltu_BrUn", BrUn, 1'b1);
    tick();
    // wrong-path branch in the redirect cycle
    drive(1, 1, 0, 3'b000, 32'h300, 32'h80, 1, 32'h80, 1, 0);
    #1;
    chk1("bltu_redirect_valid", redirect_valid, 1'b1);
    chk32("bltu_redirect_pc", redirect_pc, 32'h204);
    chk1("bltu_upd_mispred", upd_mispred, 1'b1);
    chk32("bltu_mis_cnt", mis_cnt, 32'd1);
    tick();
    idle();
    #1;
    chk1("squash_one_cycle", redirect_valid, 1'b0);
    chk32("wrongpath_br_cnt", br_cnt, 32'd2);
    tick();

    // JAL with wrong predicted target
    drive(1, 0, 1, 3'b000, 32'h400, 32'h600, 1, 32'h500, 0, 0);
    tick();
    idle();
    #1;
    chk32("jal_redirect_pc", redirect_pc, 32'h600);
    chk32("jal_mis_cnt", mis_cnt, 32'd2);
    chk1("jal_no_enqueue", upd_valid, 1'b0);
    tick();

    // Fill the update queue, stall the fifth branch, then drain
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 3'b001, 32'h1000 + 32'(4 * i), 32'h40, 1, 32'h40, 0, 0);
      tick();
    end
    drive(1, 1, 0, 3'b001, 32'h1010, 32'h40, 1, 32'h40, 0, 0);
    #1;
    chk1("full_stall", stall_ex, 1'b1);
    tick();
    tick();
    upd_ready = 1'b1;
    #1;
    chk1("stall_during_pop", stall_ex, 1'b1);
    tick();
    #1;
    chk1("stall_released", stall_ex, 1'b0);
    chk32("drain_head_order", upd_pc, 32'h1004);
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();

    // Illegal funct3 is ignored entirely
    drive(1, 1, 0, 3'b010, 32'h700, 32'h800, 1, 32'h800, 1, 1);
    tick();
    idle();
    #1;
    chk1("illegal_no_redirect", redirect_valid, 1'b0);
    chk1("illegal_no_enqueue", upd_valid, 1'b0);
    chk32("illegal_br_cnt", br_cnt, 32'd7);
    chk32("illegal_mis_cnt", mis_cnt, 32'd2);
    tick();

    // Not-taken fall-through wraps past the top of the address space
    drive(1, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 0, 0);
    tick();
    idle();
    #1;
    chk1("wrap_redirect_valid", redirect_valid, 1'b1);
    chk32("wrap_redirect_pc", redirect_pc, 32'h0);
    tick();
    tick();

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)) << 2,
            32'($urandom_range(0, 3)) << 4, 1'($urandom),
            32'($urandom_range(0, 3)) << 4, 1'($urandom), 1'($urandom));
      upd_ready = $urandom_range(0, 2) != 0;
      tick();
    end

    // Reset while squashing with three queued entries
    idle();
    upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    upd_ready = 1'b0;
    drive(1, 1, 0, 3'b001, 32'h2000, 32'h40, 1, 32'h40, 0, 0);
    tick();
    drive(1, 1, 0, 3'b001, 32'h2004, 32'h40, 1, 32'h40, 0, 0);
    tick();
    drive(1, 1, 0, 3'b001, 32'h2008, 32'h40, 1, 32'h40, 1, 0);
    tick();
    idle();
    #1;
    chk1("pre_rst_squash", redirect_valid, 1'b1);
    chk1("pre_rst_queued", upd_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst_redirect_valid", redirect_valid, 1'b0);
    chk1("async_rst_upd_valid", upd_valid, 1'b0);
    chk32("async_rst_upd_pc", upd_pc, 32'd0);
    chk32("async_rst_redirect_pc", redirect_pc, 32'd0);
    chk32("async_rst_br_cnt", br_cnt, 32'd0);
    chk32("async_rst_mis_cnt", mis_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resetModel();
    upd_ready = 1'b1;
    tick();
    drive(1, 1, 0, 3'b101, 32'h3000, 32'h3100, 0, 32'h0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
